bitwise_sequencer: RTL
======================

# bitwise_sequencer

Multi-cycle controller that wraps one `Bitwise` instance and runs multi-bit shift and rotate operations on it. Each cycle it feeds the unit `b = 1` and loops the result and carry back in. Single-pass logical ops (AND/OR/XOR/NOT/FLIP) go through in one step. It sits between the issue stage and writeback, with valid/ready handshakes on both sides.

## Interface
- `STEP_W`, default 6: width of the step-count field (max 63 steps).
- `clk` input, 1 bit: clock, rising edge.
- `rst_n` input, 1 bit: asynchronous reset, active-low.
- `flush` input, 1 bit: synchronous abort of any in-flight or pending operation.
- `req_valid` input, 1 bit: request present.
- `req_ready` output, 1 bit: sequencer can accept a request.
- `req_op` input, `opcode_t`: operation.
- `req_size` input, `sizeFlags_t`: operand width (BITS_8/16/32/64).
- `req_use_carry` input, 1 bit: through-carry mode.
- `req_carry_in` input, 1 bit: initial carry.
- `req_a` input, `ulong_t`: operand A.
- `req_b` input, `ulong_t`: operand B (logical ops only).
- `req_count` input, `STEP_W` bits: step count (shift/rotate ops only).
- `rsp_valid` output, 1 bit: result available.
- `rsp_ready` input, 1 bit: consumer accepts the result.
- `rsp_result` output, `ulong_t`: final result.
- `rsp_carry` output, 1 bit: final carry.
- `busy` output, 1 bit: state is not IDLE.

## Operation
- States are IDLE, RUN and DONE.
- **IDLE:**
  - `req_ready = !flush`.
  - An accept happens on `req_valid && req_ready`. It latches `op`, `size`, `use_carry`, `acc <= req_a`, `cy <= req_carry_in`, `b_reg <= req_b`.
  - Step count `k`: ROLR/ROLL/SHIFTR/SHIFTL use `k = req_count`; AND/OR/XOR/NOT/FLIP use `k = 1`; any other opcode uses `k = 0`.
  - If `k == 0`, go to DONE; otherwise set `remaining <= k` and go to RUN.
- **RUN:**
  - Bitwise inputs: `a = acc`, `carryIn = cy`, `useCarry = use_carry`, `size = size`.
  - `b = 1` for shift/rotate ops; `b = b_reg` for logical ops.
  - Each edge: `acc <= result`, `cy <= carry`, `remaining <= remaining - 1`.
  - Go to DONE when `remaining == 1`.
- **DONE:**
  - `rsp_valid = 1`; `rsp_result = acc` and `rsp_carry = cy`, both held stable.
  - On `rsp_ready`, go to IDLE.
  - `req_ready = 0`: there is no overlap of response and new request.
- **Result bits:** no masking by the sequencer. Bits above `size` are whatever Bitwise produces; on the zero-step path they are `req_a` unchanged.
- **flush:**
  - Any state goes to IDLE on the next edge; a pending response is dropped.
  - When flush and `req_valid` are high in the same IDLE cycle, flush wins and nothing is accepted.
- **Reset:** asynchronous, in any state including mid-RUN.
  - State goes to IDLE; `acc`, `cy`, `remaining` and `b_reg` are cleared.
  - Output reset values: `req_ready = 1`, `rsp_valid = 0`, `rsp_result = 0`, `rsp_carry = 0`, `busy = 0`.
- `remaining` never wraps: RUN is entered only with `k ≥ 1`.

## Timing
- Accept edge at the end of cycle N.
- RUN occupies cycles N+1 through N+k.
- `rsp_valid` first asserts in cycle N+k+1. For `k = 0` it asserts in cycle N+1.
- Throughput is one operation per k+2 cycles minimum: accept, k steps, then the DONE handshake cycle.
- All outputs are registered or decoded from state only. There is no combinational path from `rsp_ready` to `req_ready` within a cycle.

## Structure
- Reuse `opcode_t`, `sizeFlags_t` and `ulong_t` from the shared `types` and `instructions` packages.
- Add the state enum `bitseq_state_t` (IDLE, RUN, DONE) to `types`.
- Add a helper function `is_multistep(opcode_t)` to `instructions`.
- The one natural sub-module is the existing `Bitwise` unit, instantiated once. The rest is a single-module FSM plus datapath registers.

## Test plan
- **Rotate left, 8-bit:** ROLL, BITS_8, `a=0x81`, `count=3`, `use_carry=0` → `rsp_result=0x0C`, `rsp_carry=0`, `rsp_valid` 4 cycles after accept.
- **Rotate right through carry, 8-bit:** ROLR, BITS_8, `a=1`, `count=2`, `use_carry=1`, `carry_in=0` → step 1 gives result 0 with carry 1; final `rsp_result=0x80`, `rsp_carry=0`.
- **Logical op and zero-step path:**
  - AND, `a=3`, `b=1` → `rsp_result=1`, `rsp_valid` 2 cycles after accept.
  - SHIFTL, `count=0`, `a=0x1234`, `carry_in=1` → `rsp_result=0x1234`, `rsp_carry=1`, `rsp_valid` the next cycle.
- **Backpressure:** SHIFTR, BITS_16, `a=0x00F0`, `count=4` → `0x000F`.
  - Hold `rsp_ready=0` for 5 cycles: result and carry stay stable, `req_ready=0`, a `req_valid` pulse is ignored.
  - Release `rsp_ready`: IDLE on the next cycle.
- **Flush:**
  - ROLR, BITS_64, `count=63`; flush at step 10 → `busy=0` the next cycle, `rsp_valid` never asserts.
  - Flush coincident with `req_valid` in IDLE → no accept.
- **Reset mid-RUN:** drop `rst_n` asynchronously mid-RUN → all outputs at reset values immediately. After release, a fresh ROLL `a=1 count=1` at BITS_8 returns `0x02`.

Source files
------------

// File: rtl/instructions.sv
// Opcode set for the bitwise unit plus opcode classification helpers.
package instructions;

    typedef enum logic [3:0] {
        NOP    = 4'd0,
        AND    = 4'd1,
        OR     = 4'd2,
        XOR    = 4'd3,
        NOT    = 4'd4,
        FLIP   = 4'd5,
        SHIFTL = 4'd6,
        SHIFTR = 4'd7,
        ROLL   = 4'd8,
        ROLR   = 4'd9,
        ADD    = 4'd10
    } opcode_t;

    // Shift/rotate ops: one bit position per Bitwise pass.
    function automatic logic is_multistep(opcode_t op);
        return op inside {SHIFTL, SHIFTR, ROLL, ROLR};
    endfunction

    function automatic logic is_logical(opcode_t op);
        return op inside {AND, OR, XOR, NOT, FLIP};
    endfunction

endpackage

// File: rtl/types.sv
// Shared datapath types: operand word, operand-size flags and sequencer states.
package types;

    localparam int unsigned ULONG_W = 64;

    typedef logic [ULONG_W-1:0] ulong_t;

    typedef enum logic [1:0] {
        BITS_8  = 2'd0,
        BITS_16 = 2'd1,
        BITS_32 = 2'd2,
        BITS_64 = 2'd3
    } sizeFlags_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } bitseq_state_t;

endpackage

// File: rtl/Bitwise.sv
// Single-pass bitwise unit: logical ops, or a one-position shift/rotate when b is nonzero.
// Results are confined to the selected operand width; upper bits come out zero.
module Bitwise
    import types::*;
    import instructions::*;
(
    input  opcode_t    op,
    input  sizeFlags_t size,
    input  ulong_t     a,
    input  ulong_t     b,
    input  logic       carryIn,
    input  logic       useCarry,
    output ulong_t     result,
    output logic       carry
);

    ulong_t     mask;
    ulong_t     am;
    ulong_t     rev;
    logic [5:0] msbIdx;
    logic       msb;
    logic       lsb;
    logic       fill;
    logic       doShift;

    always_comb begin
        mask   = 64'h0000_0000_0000_00FF;
        msbIdx = 6'd7;
        case (size)
            BITS_8:  begin mask = 64'h0000_0000_0000_00FF; msbIdx = 6'd7;  end
            BITS_16: begin mask = 64'h0000_0000_0000_FFFF; msbIdx = 6'd15; end
            BITS_32: begin mask = 64'h0000_0000_FFFF_FFFF; msbIdx = 6'd31; end
            default: begin mask = 64'hFFFF_FFFF_FFFF_FFFF; msbIdx = 6'd63; end
        endcase

        am      = a & mask;
        rev     = {<<{am}};
        msb     = a[msbIdx];
        lsb     = a[0];
        doShift = (b != '0);
        fill    = 1'b0;
        result  = am;
        carry   = carryIn;

        case (op)
            AND:  result = a & b & mask;
            OR:   result = (a | b) & mask;
            XOR:  result = (a ^ b) & mask;
            NOT:  result = ~a & mask;
            FLIP: result = rev >> (6'd63 - msbIdx);
            SHIFTL, ROLL: if (doShift) begin
                fill   = useCarry ? carryIn : ((op == ROLL) ? msb : 1'b0);
                result = ((am << 1) & mask) | {63'd0, fill};
                carry  = msb;
            end
            SHIFTR, ROLR: if (doShift) begin
                fill   = useCarry ? carryIn : ((op == ROLR) ? lsb : 1'b0);
                result = (am >> 1) | (ULONG_W'(fill) << msbIdx);
                carry  = lsb;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/bitwise_sequencer.sv
// Multi-cycle controller around one Bitwise unit: repeats single-bit shift/rotate
// passes with the result and carry fed back, and passes logical ops through in one step.
module bitwise_sequencer
    import types::*;
    import instructions::*;
#(
    parameter int unsigned STEP_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              req_valid,
    output logic              req_ready,
    input  opcode_t           req_op,
    input  sizeFlags_t        req_size,
    input  logic              req_use_carry,
    input  logic              req_carry_in,
    input  ulong_t            req_a,
    input  ulong_t            req_b,
    input  logic [STEP_W-1:0] req_count,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output ulong_t            rsp_result,
    output logic              rsp_carry,
    output logic              busy
);

    bitseq_state_t     state, nextState;
    opcode_t           opReg, opNext;
    sizeFlags_t        sizeReg, sizeNext;
    logic              useCarryReg, useCarryNext;
    ulong_t            acc, accNext;
    logic              cy, cyNext;
    ulong_t            bReg, bRegNext;
    logic [STEP_W-1:0] remaining, remainingNext;
    logic [STEP_W-1:0] stepK;
    ulong_t            bOperand;
    ulong_t            bwResult;
    logic              bwCarry;

    assign bOperand   = is_multistep(opReg) ? ULONG_W'(1) : bReg;
    assign rsp_result = acc;
    assign rsp_carry  = cy;

    Bitwise uBitwise (
        .op       (opReg),
        .size     (sizeReg),
        .a        (acc),
        .b        (bOperand),
        .carryIn  (cy),
        .useCarry (useCarryReg),
        .result   (bwResult),
        .carry    (bwCarry)
    );

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            opReg       <= NOP;
            sizeReg     <= BITS_8;
            useCarryReg <= 1'b0;
            acc         <= '0;
            cy          <= 1'b0;
            bReg        <= '0;
            remaining   <= '0;
        end else begin
            state       <= nextState;
            opReg       <= opNext;
            sizeReg     <= sizeNext;
            useCarryReg <= useCarryNext;
            acc         <= accNext;
            cy          <= cyNext;
            bReg        <= bRegNext;
            remaining   <= remainingNext;
        end
    end

    // Next-state, datapath updates and state-decoded handshake outputs.
    always_comb begin
        nextState     = state;
        opNext        = opReg;
        sizeNext      = sizeReg;
        useCarryNext  = useCarryReg;
        accNext       = acc;
        cyNext        = cy;
        bRegNext      = bReg;
        remainingNext = remaining;
        req_ready     = 1'b0;
        rsp_valid     = 1'b0;
        busy          = (state != IDLE);

        if (is_multistep(req_op)) begin
            stepK = req_count;
        end else if (is_logical(req_op)) begin
            stepK = STEP_W'(1);
        end else begin
            stepK = '0;
        end

        case (state)
            IDLE: begin
                req_ready = !flush;
                if (req_valid && !flush) begin
                    opNext       = req_op;
                    sizeNext     = req_size;
                    useCarryNext = req_use_carry;
                    accNext      = req_a;
                    cyNext       = req_carry_in;
                    bRegNext     = req_b;
                    if (stepK == '0) begin
                        nextState = DONE;
                    end else begin
                        remainingNext = stepK;
                        nextState     = RUN;
                    end
                end
            end
            RUN: begin
                accNext       = bwResult;
                cyNext        = bwCarry;
                remainingNext = remaining - STEP_W'(1);
                if (remaining == STEP_W'(1)) begin
                    nextState = DONE;
                end
            end
            DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase

        // An abort freezes the datapath and drops any pending response.
        if (flush) begin
            nextState     = IDLE;
            accNext       = acc;
            cyNext        = cy;
            remainingNext = remaining;
        end
    end

endmodule
